// File: rtl/mix_i2s_out_if.sv
// Mixer-to-DAC bus: mixed sample and volume in, I2S pins and monitor word out.
// The mixer side uses the master modport and the output stage uses the slave modport.
interface mix_i2s_out_if #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16
);
   logic [IN_W-1:0]  mixed_signal;
   logic [2:0]       vol;
   logic             bclk;
   logic             lrclk;
   logic             sdata;
   logic             sample_tick;
   logic [OUT_W-1:0] sample_out;

   modport master (output mixed_signal, vol,
                   input  bclk, lrclk, sdata, sample_tick, sample_out);
   modport slave  (input  mixed_signal, vol,
                   output bclk, lrclk, sdata, sample_tick, sample_out);
endinterface

// File: rtl/mix_i2s_out.sv
// Mixer output stage: re-centre, shift-volume, saturate, then serialise as mono I2S.
// Emits a one-clk sample_tick at every frame capture.
module mix_i2s_out #(
   parameter int IN_W     = 20,
   parameter int OUT_W    = 16,
   parameter int BCLK_DIV = 4
)(
   input  logic         clk,
   input  logic         reset,
   mix_i2s_out_if.slave bus
);
   localparam int FRAME = 2 * OUT_W;
   localparam int BW    = $clog2(FRAME);
   localparam int DW    = $clog2(BCLK_DIV);
   localparam int BASE  = IN_W - OUT_W;

   localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2 - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [BW-1:0] B_LAST   = BW'(FRAME - 1);
   localparam logic [BW-1:0] B_RIGHT  = BW'(OUT_W);
   localparam logic [BW-1:0] B_FRAME  = BW'(FRAME);
   localparam logic signed [IN_W-1:0] S_MAX = IN_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [IN_W-1:0] S_MIN = ~S_MAX;

   logic [DW-1:0]    div_q, div_d;
   logic [BW-1:0]    b_q, b_d;
   logic [FRAME-1:0] frame_q, frame_d;
   logic             bclk_q, bclk_d;
   logic             lrclk_q, lrclk_d;
   logic             sdata_q, sdata_d;
   logic             tick_q, tick_d;
   logic [OUT_W-1:0] sout_q, sout_d;

   logic                   fall;
   logic [BW-1:0]          idx;
   logic signed [IN_W-1:0] s_c, y_c;
   logic [OUT_W-1:0]       sat_c;
   int                     e_c;

   // Flipping the MSB of offset-binary gives the two's-complement value minus the midpoint.
   always_comb begin
      s_c = $signed({~bus.mixed_signal[IN_W-1], bus.mixed_signal[IN_W-2:0]});
      e_c = BASE - ((int'(bus.vol) > BASE) ? BASE : int'(bus.vol));
      y_c = s_c >>> e_c;
      if (y_c > S_MAX)
         sat_c = S_MAX[OUT_W-1:0];
      else if (y_c < S_MIN)
         sat_c = S_MIN[OUT_W-1:0];
      else
         sat_c = y_c[OUT_W-1:0];
   end

   always_comb begin
      fall    = (div_q == DIV_LAST);
      div_d   = fall ? '0 : div_q + 1'b1;
      b_d     = b_q;
      bclk_d  = bclk_q;
      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      frame_d = frame_q;
      sout_d  = sout_q;
      tick_d  = 1'b0;
      idx     = '0;
      if (div_q == DIV_HALF)
         bclk_d = 1'b1;
      if (fall) begin
         bclk_d  = 1'b0;
         b_d     = (b_q == B_LAST) ? '0 : b_q + 1'b1;
         lrclk_d = (b_d >= B_RIGHT);
         if (b_q == B_LAST) begin
            // Period 0 still carries the old frame's LSB (one-bit I2S delay).
            sdata_d = frame_q[0];
            frame_d = {sat_c, sat_c};
            sout_d  = sat_c;
            tick_d  = 1'b1;
         end else begin
            idx     = B_FRAME - b_d;
            sdata_d = frame_q[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q   <= '0;
         b_q     <= B_LAST;
         frame_q <= '0;
         bclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
         sdata_q <= 1'b0;
         tick_q  <= 1'b0;
         sout_q  <= '0;
      end else begin
         div_q   <= div_d;
         b_q     <= b_d;
         frame_q <= frame_d;
         bclk_q  <= bclk_d;
         lrclk_q <= lrclk_d;
         sdata_q <= sdata_d;
         tick_q  <= tick_d;
         sout_q  <= sout_d;
      end
   end

   assign bus.bclk        = bclk_q;
   assign bus.lrclk       = lrclk_q;
   assign bus.sdata       = sdata_q;
   assign bus.sample_tick = tick_q;
   assign bus.sample_out  = sout_q;
endmodule

// File: tb/tb_mix_i2s_out.sv
// Self-checking bench for mix_i2s_out: directed corner frames plus random frames
// checked every clk against a time-indexed frame model.
module tb_mix_i2s_out;
   localparam int IN_W  = 20;
   localparam int OUT_W = 16;
   localparam int DIV   = 4;
   localparam int FRAME = 2 * OUT_W;
   localparam int FCLK  = FRAME * DIV;

   logic clk = 1'b0;
   logic reset;

   mix_i2s_out_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bif();

   mix_i2s_out #(.IN_W(IN_W), .OUT_W(OUT_W), .BCLK_DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int t     = 0;
   int mix_v = 0;
   int vol_v = 0;
   logic [OUT_W-1:0] cur_s  = '0;
   logic [OUT_W-1:0] prev_s = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (clk %0d after reset)", tag, obs, exp, t);
      end
   endtask

   // Expected DAC word straight from the arithmetic rules: centre, divide by 2^e (floor), clamp.
   function automatic logic [OUT_W-1:0] ref_word(input int m, input int v);
      int s, vv, d, y, base;
      base = IN_W - OUT_W;
      s  = m - (1 << (IN_W - 1));
      vv = (v > base) ? base : v;
      d  = 1 << (base - vv);
      y  = (s >= 0) ? s / d : -((-s + d - 1) / d);
      if (y > (1 << (OUT_W - 1)) - 1) y = (1 << (OUT_W - 1)) - 1;
      if (y < -(1 << (OUT_W - 1)))    y = -(1 << (OUT_W - 1));
      return y[OUT_W-1:0];
   endfunction

   function automatic bit is_cap(input int tt);
      return (tt >= DIV) && ((tt - DIV) % FCLK == 0);
   endfunction

   function automatic int period(input int tt);
      return (tt < DIV) ? -1 : ((tt - DIV) / DIV) % FRAME;
   endfunction

   task automatic set_in(input int m, input int v);
      mix_v = m;
      vol_v = v;
      bif.mixed_signal = IN_W'(m);
      bif.vol          = 3'(v);
   endtask

   // One clk: advance the model on the edge, then compare every output 1 time unit later.
   task automatic step();
      int   b;
      logic e_lr, e_sd;
      @(posedge clk);
      t++;
      if (is_cap(t)) begin
         prev_s = cur_s;
         cur_s  = ref_word(mix_v, vol_v);
      end
      #1;
      b    = period(t);
      e_lr = 1'b0;
      e_sd = 1'b0;
      if (b >= 0) begin
         e_lr = (b >= OUT_W);
         if (b == 0)          e_sd = prev_s[0];
         else if (b <= OUT_W) e_sd = cur_s[OUT_W-b];
         else                 e_sd = cur_s[FRAME-b];
      end
      chk("sample_tick", 32'(bif.sample_tick), 32'(is_cap(t)));
      chk("bclk",        32'(bif.bclk),        32'((t % DIV) >= DIV / 2));
      chk("lrclk",       32'(bif.lrclk),       32'(e_lr));
      chk("sdata",       32'(bif.sdata),       32'(e_sd));
      chk("sample_out",  32'(bif.sample_out),  32'(cur_s));
   endtask

   task automatic to_cap();
      for (int i = 0; i < FCLK + DIV; i++) begin
         step();
         if (is_cap(t)) break;
      end
      chk("cap_reached", 32'(is_cap(t)), 32'd1);
   endtask

   task automatic to_b(input int bb);
      for (int i = 0; i < FCLK; i++) begin
         step();
         if (period(t) == bb && (t % DIV) == 0) break;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_bclk",   32'(bif.bclk),        32'd0);
      chk("rst_lrclk",  32'(bif.lrclk),       32'd0);
      chk("rst_sdata",  32'(bif.sdata),       32'd0);
      chk("rst_tick",   32'(bif.sample_tick), 32'd0);
      chk("rst_sample", 32'(bif.sample_out),  32'd0);
      repeat (3) @(negedge clk);
      reset  = 1'b1;
      t      = 0;
      cur_s  = '0;
      prev_s = '0;
   endtask

   task automatic word(input string tag, input int m, input int v, input logic [OUT_W-1:0] exp);
      set_in(m, v);
      to_cap();
      chk(tag, 32'(bif.sample_out), 32'(exp));
   endtask

   initial begin
      set_in(20'h80000, 0);
      do_reset();

      // Silence; first tick 4 clks after release, then every frame.
      to_cap();
      chk("first_tick", 32'(bif.sample_tick), 32'd1);
      chk("silence", 32'(bif.sample_out), 32'h0000);
      to_cap();

      word("full_pos", 20'hFFFFF, 0, 16'h7FFF);
      word("full_neg", 20'h00000, 0, 16'h8000);
      word("mid_again", 20'h80000, 0, 16'h0000);

      for (int v = 4; v <= 7; v += 3) begin
         word("v_clamp_hi", 20'h88000, v, 16'h7FFF);
         word("v_clamp_lo", 20'h77000, v, 16'h8000);
         word("v_small",    20'h80123, v, 16'h0123);
      end

      // Input change mid-frame must wait for the next capture.
      word("hold_a", 20'h80123, 4, 16'h0123);
      to_b(5);
      set_in(20'h88000, 4);
      to_b(20);
      chk("hold_inflight", 32'(bif.sample_out), 32'h0123);
      to_cap();
      chk("hold_next", 32'(bif.sample_out), 32'h7FFF);

      repeat (12) begin
         set_in(int'($urandom_range((1 << IN_W) - 1, 0)), int'($urandom_range(7, 0)));
         to_cap();
         to_b(int'($urandom_range(FRAME - 1, 1)));
         set_in(int'($urandom_range((1 << IN_W) - 1, 0)), int'($urandom_range(7, 0)));
      end
      to_cap();

      // Async reset in period 9, then a clean restart.
      set_in(20'hFFFFF, 0);
      to_cap();
      to_b(9);
      step();
      do_reset();
      set_in(20'h80123, 4);
      to_cap();
      chk("restart_tick", 32'(bif.sample_tick), 32'd1);
      chk("restart_word", 32'(bif.sample_out), 32'h0123);
      to_cap();
      to_cap();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
